mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the data-memory map (RAM 0x000-0x7FF, ROM 0x800-0xFFF, text RAM >=0x1000) between the
//  ARM core data port and the VGA text reader. Round-trip FSM per access: arbitrate, drive the
//  shared memory bus, return sync-read data with a one-cycle ack. VGA wins by default; a
//  starvation counter guarantees the core a slot.
// PARAMETERS
//  size     32  address/data width, bits
//  VGA_MAX  4   max consecutive VGA grants while cpu_req is pending (>=1)
// PORTS
//  clk         in   1     system clock, rising edge
//  reset       in   1     asynchronous, active-low reset
//  cpu_req     in   1     core request; held with addr/we/wdata until cpu_ack
//  cpu_we      in   1     1 = write, 0 = read
//  cpu_addr    in   size  core byte address
//  cpu_wdata   in   size  core write data
//  cpu_rdata   out  size  read data, valid while cpu_ack=1
//  cpu_ack     out  1     one-cycle completion pulse
//  vga_req     in   1     VGA read request; held with vga_addr until vga_ack
//  vga_addr    in   size  VGA byte address (read-only port)
//  vga_rdata   out  size  read data, valid while vga_ack=1
//  vga_ack     out  1     one-cycle completion pulse
//  mem_addr    out  size  shared address to RAM/ROM/text RAM
//  mem_wdata   out  size  shared write data
//  ram_we      out  1     RAM write enable (ACCESS cycle only)
//  text_we     out  1     text RAM write enable (ACCESS cycle only)
//  ram_rdata   in   size  RAM sync-read data, valid 1 cycle after address
//  rom_rdata   in   size  ROM sync-read data, valid 1 cycle after address
//  text_rdata  in   size  text RAM sync-read data, valid 1 cycle after address
//  busy        out  1     1 when FSM not in IDLE
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, owner=none, vga_cnt=0, all outputs 0 (rdata buses 0).
//  FSM: IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles, no pipelining.
//  IDLE: sample requests. Neither -> stay. One -> grant it. Both -> VGA unless vga_cnt==VGA_MAX,
//   then CPU. Registered owner, addr, we, wdata, region; go ACCESS.
//  vga_cnt: +1 on each VGA grant while cpu_req=1; cleared on CPU grant or when cpu_req=0 in IDLE.
//   Saturates at VGA_MAX.
//  Decode on latched addr: 0x000-0x7FF RAM; 0x800-0xFFF ROM; >=0x1000 text RAM (full width compare).
//  ACCESS: mem_addr/mem_wdata driven from latch; ram_we=1 iff CPU write to RAM; text_we=1 iff CPU
//   write to text. CPU write to ROM: no strobe, silently dropped, still acked. VGA never writes.
//  RESP: rdata selected by latched region (RAM/ROM/text) to owner's rdata; owner's ack=1 this
//   cycle only; other port's ack=0 and rdata=0. Writes also ack in RESP (rdata=0).
//  mem_addr/mem_wdata hold last value outside ACCESS; write enables 0 outside ACCESS.
//  Requester holding req high after ack is re-arbitrated in the following IDLE (no back-to-back
//   without IDLE). Requests changing mid-transaction are ignored (latched copy used).
//  req dropped before ack: transaction still completes; ack pulses anyway.
//  Reset mid-operation: aborts immediately, write strobe drops, no ack issued.
// TESTING
//  1 CPU write 0x0000_0010 data 0xDEAD_BEEF -> ram_we=1 in cycle 2 only, cpu_ack cycle 3; readback = 0xDEAD_BEEF.
//  2 CPU write 0x0000_0900 -> ram_we=text_we=0, cpu_ack pulses; CPU read 0x900 returns rom_rdata.
//  3 CPU+VGA both held high, VGA_MAX=4 -> grant order V,V,V,V,C,V,V,V,V,C; vga_cnt back to 0 after C.
//  4 VGA read 0x0000_1004 alone -> mem_addr=0x1004 in ACCESS, vga_rdata=text_rdata, vga_ack cycle 3, cpu_ack=0.
//  5 reset=0 asserted during ACCESS of CPU text write -> text_we falls async, busy=0, no cpu_ack.
//  6 CPU addr changed during ACCESS -> mem_addr keeps latched value; ack/data match original address.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared data-memory arbiter between core data port and VGA text reader
module mem_arbiter #(
  parameter int size    = 32,
  parameter int VGA_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [size-1:0] cpu_addr,
  input  logic [size-1:0] cpu_wdata,
  output logic [size-1:0] cpu_rdata,
  output logic            cpu_ack,
  input  logic            vga_req,
  input  logic [size-1:0] vga_addr,
  output logic [size-1:0] vga_rdata,
  output logic            vga_ack,
  output logic [size-1:0] mem_addr,
  output logic [size-1:0] mem_wdata,
  output logic            ram_we,
  output logic            text_we,
  input  logic [size-1:0] ram_rdata,
  input  logic [size-1:0] rom_rdata,
  input  logic [size-1:0] text_rdata,
  output logic            busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_VGA  = 2'd2;

  localparam logic [1:0] RG_RAM  = 2'd0;
  localparam logic [1:0] RG_ROM  = 2'd1;
  localparam logic [1:0] RG_TEXT = 2'd2;

  localparam int CW = (VGA_MAX < 1) ? 1 : $clog2(VGA_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(VGA_MAX);

  logic [1:0]      state;
  logic [1:0]      owner;
  logic [1:0]      region;
  logic            lat_we;
  logic [size-1:0] lat_addr;
  logic [size-1:0] lat_wdata;
  logic [CW-1:0]   vga_cnt;
  logic            grant_cpu;
  logic            grant_vga;
  logic            wr_access;
  logic [size-1:0] sel_rdata;

  // Full-width address compare; everything at or above the text base is text RAM.
  function automatic logic [1:0] decode(input logic [size-1:0] a);
    if (a < size'(32'h0000_0800))
      return RG_RAM;
    else if (a < size'(32'h0000_1000))
      return RG_ROM;
    else
      return RG_TEXT;
  endfunction

  // Arbitration: VGA wins unless it has starved the core for VGA_MAX grants.
  always_comb begin
    grant_cpu = 1'b0;
    grant_vga = 1'b0;
    if (state == IDLE) begin
      if (vga_req && (!cpu_req || vga_cnt != CNT_MAX))
        grant_vga = 1'b1;
      else if (cpu_req)
        grant_cpu = 1'b1;
    end
  end

  // Round-trip FSM; the winner's request is latched so later changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      region    <= RG_RAM;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state     <= ACCESS;
            owner     <= OWN_CPU;
            lat_addr  <= cpu_addr;
            lat_we    <= cpu_we;
            lat_wdata <= cpu_wdata;
            region    <= decode(cpu_addr);
          end else if (grant_vga) begin
            state     <= ACCESS;
            owner     <= OWN_VGA;
            lat_addr  <= vga_addr;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            region    <= decode(vga_addr);
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Starvation counter: counts VGA wins while the core waits, clears once the core is served or idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_cpu || !cpu_req)
        vga_cnt <= '0;
      else if (grant_vga && vga_cnt != CNT_MAX)
        vga_cnt <= vga_cnt + 1'b1;
    end
  end

  // Read-data mux by latched region; memories return data in the cycle after ACCESS.
  always_comb begin
    sel_rdata = '0;
    case (region)
      RG_RAM:  sel_rdata = ram_rdata;
      RG_ROM:  sel_rdata = rom_rdata;
      RG_TEXT: sel_rdata = text_rdata;
      default: sel_rdata = '0;
    endcase
  end

  // Bus address/data come straight from the latch, so they hold between accesses.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Strobes decode from state so an async reset drops them immediately; ROM writes get no strobe.
  assign wr_access = (state == ACCESS) && (owner == OWN_CPU) && lat_we;
  assign ram_we    = wr_access && (region == RG_RAM);
  assign text_we   = wr_access && (region == RG_TEXT);

  assign cpu_ack   = (state == RESP) && (owner == OWN_CPU);
  assign vga_ack   = (state == RESP) && (owner == OWN_VGA);
  assign cpu_rdata = (cpu_ack && !lat_we) ? sel_rdata : '0;
  assign vga_rdata = vga_ack ? sel_rdata : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        vga_req = 1'b0;
  logic [31:0] vga_addr = '0;
  logic [31:0] vga_rdata;
  logic        vga_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        ram_we;
  logic        text_we;
  logic [31:0] ram_rdata = '0;
  logic [31:0] rom_rdata = '0;
  logic [31:0] text_rdata = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_vga;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        is_vga;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[14];
  logic preload = 1'b1;

  logic [31:0] ram_mem [512];
  logic [31:0] text_mem [256];

  mem_arbiter #(.size(32), .VGA_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_ack(vga_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ram_we(ram_we), .text_we(text_we),
    .ram_rdata(ram_rdata), .rom_rdata(rom_rdata), .text_rdata(text_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sync-read memory models: RAM and text RAM preloaded with index patterns, ROM = addr ^ A5A50000.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= 32'h1000_0000 + 32'(i);
      for (int i = 0; i < 256; i++) text_mem[i] <= 32'h2000_0000 + 32'(i);
    end else begin
      if (ram_we)  ram_mem[mem_addr[10:2]] <= mem_wdata;
      if (text_we) text_mem[mem_addr[9:2]] <= mem_wdata;
    end
    ram_rdata  <= ram_mem[mem_addr[10:2]];
    text_rdata <= text_mem[mem_addr[9:2]];
    rom_rdata  <= mem_addr ^ 32'hA5A5_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expectation and compares port and data.
  always @(negedge clk) begin
    if (cpu_ack && vga_ack) begin
      chk("dual_ack", 32'd1, 32'd0);
    end else if (cpu_ack || vga_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {31'd0, vga_ack}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'd0, vga_ack}, {31'd0, e.is_vga});
        chk("ack_rdata", vga_ack ? vga_rdata : cpu_rdata, e.data);
        chk("idle_port_rdata", vga_ack ? cpu_rdata : vga_rdata, 32'h0);
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int  n;
    bit  got;
    int  extra;
    logic exp_ram;
    logic exp_text;
    exp_ram  = !v.is_vga && v.we && (v.addr < 32'h800);
    exp_text = !v.is_vga && v.we && (v.addr >= 32'h1000);
    @(negedge clk);
    if (v.is_vga) begin
      vga_req = 1'b1; vga_addr = v.addr;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    sb.push_back('{v.is_vga, v.exp_rdata});
    got = 1'b0; n = 0; extra = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("access_mem_addr", mem_addr, v.addr);
        chk("access_ram_we", {31'd0, ram_we}, {31'd0, exp_ram});
        chk("access_text_we", {31'd0, text_we}, {31'd0, exp_text});
        if (v.we && !v.is_vga) chk("access_mem_wdata", mem_wdata, v.wdata);
      end else if (ram_we || text_we) begin
        extra++;
      end
      if (cpu_ack || vga_ack) got = 1'b1;
    end
    chk("ack_latency", 32'(n), 32'd2);
    chk("stray_strobe", 32'(extra), 32'd0);
    cpu_req = 1'b0;
    vga_req = 1'b0;
  endtask

  initial begin
    int n;
    int acks;
    vec_t v;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0900, 32'h1234_5678, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0900, 32'h0,         32'hA5A5_0900};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_07FC, 32'h0,         32'h1000_01FF};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0800, 32'h0,         32'hA5A5_0800};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h1000_0000};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_0FFC};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h2000_0000};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_07FC, 32'h0F0F_0F0F, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_07FC, 32'h0,         32'h0F0F_0F0F};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_07FC, 32'h0,         32'h0F0F_0F0F};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_vga_ack", {31'd0, vga_ack}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_text_we", {31'd0, text_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_vga_rdata", vga_rdata, 32'h0);
    reset = 1'b1;
    preload = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 14; i++) run_txn(vecs[i]);

    // Both requesters held: four VGA grants, then the core, repeated; 3 cycles per access
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) sb.push_back('{1'b0, 32'h1000_0008});
      else              sb.push_back('{1'b1, 32'h2000_0002});
    end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
    vga_req = 1'b1; vga_addr = 32'h0000_1008;
    acks = 0; n = 0;
    while (acks < 10 && n < 60) begin
      @(negedge clk);
      n++;
      if (cpu_ack || vga_ack) acks++;
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    chk("arb_ack_count", 32'(acks), 32'd10);
    chk("arb_cycles", 32'(n), 32'd29);

    // Address changed mid-transaction: latched address wins
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0014;
    sb.push_back('{1'b0, 32'h1000_0005});
    @(negedge clk);
    cpu_addr = 32'h0000_1000;
    chk("latched_addr_access", mem_addr, 32'h0000_0014);
    @(negedge clk);
    chk("latched_addr_resp", mem_addr, 32'h0000_0014);
    chk("latched_ack", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;

    // Reset during ACCESS of a core text write: strobe drops at once, no ack
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1010; cpu_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("abort_text_we_pre", {31'd0, text_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_text_we", {31'd0, text_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("abort_no_ack", {31'd0, cpu_ack}, 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    reset = 1'b1;
    v = '{1'b0, 1'b0, 32'h0000_1010, 32'h0, 32'h2000_0004};
    run_txn(v);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
